// File: rtl/zap_ram_fifo_ctrl.sv
// zap_ram_fifo_ctrl
//   FIFO controller wrapped around a zap_ram_simple instance whose read data
//   arrives 3 cycles after the address is issued (RAM clock enable tied
//   high). The controller drives the RAM write and read ports and tracks the
//   reads still in flight. It presents a first-word-fall-through valid/ready
//   read interface through a 5-entry register skid buffer.
//
// Ports
//   i_clk, i_reset_n     clock, asynchronous active-low reset
//   i_clear              synchronous flush, overrides everything else
//   i_wr_valid/o_wr_ready/i_wr_data    write handshake
//   o_rd_valid/i_rd_ready/o_rd_data    read handshake (head of skid buffer)
//   o_level              total occupancy (RAM + in flight + skid)
//   o_ram_wr_en/o_ram_wr_addr/o_ram_wr_data   RAM write port
//   o_ram_rd_addr        RAM read address (read-issue pointer)
//   i_ram_rd_data        RAM read data, 3 cycles after issue
module zap_ram_fifo_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_clear,
    input  logic                       i_wr_valid,
    output logic                       o_wr_ready,
    input  logic [WIDTH-1:0]           i_wr_data,
    output logic                       o_rd_valid,
    input  logic                       i_rd_ready,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_ram_wr_en,
    output logic [$clog2(DEPTH)-1:0]   o_ram_wr_addr,
    output logic [WIDTH-1:0]           o_ram_wr_data,
    output logic [$clog2(DEPTH)-1:0]   o_ram_rd_addr,
    input  logic [WIDTH-1:0]           i_ram_rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int SKID_DEPTH = 5;
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      ram_count;
    logic [AW:0]      level;
    logic             v1, v2, v3;
    logic [WIDTH-1:0] skid_mem [SKID_DEPTH];
    logic [2:0]       skid_head;
    logic [2:0]       skid_tail;
    logic [2:0]       skid_count;

    logic       wr_fire;
    logic       issue;
    logic       pop;
    logic       push;
    logic [3:0] pending;

    function automatic logic [2:0] skid_inc(input logic [2:0] p);
        return (p == 3'(SKID_DEPTH - 1)) ? 3'd0 : p + 3'd1;
    endfunction

    // Readiness uses the registered level only, so a same-cycle pop at full
    // never lets a write in.
    assign o_wr_ready    = (level < FULL_LEVEL);
    assign wr_fire       = i_wr_valid & o_wr_ready & ~i_clear;
    assign o_level       = level;
    assign o_rd_valid    = (skid_count != 3'd0);
    assign o_rd_data     = skid_mem[skid_head];
    assign pop           = o_rd_valid & i_rd_ready & ~i_clear;
    assign push          = v3;

    assign o_ram_wr_en   = wr_fire;
    assign o_ram_wr_addr = wr_ptr;
    assign o_ram_wr_data = i_wr_data;
    assign o_ram_rd_addr = rd_ptr;

    // Reads are issued only while the skid buffer can absorb every read
    // already in flight plus this one, even if the consumer never pops.
    assign pending = {1'b0, skid_count} + {3'b000, v1} + {3'b000, v2} + {3'b000, v3};
    assign issue   = (ram_count != '0) & (pending < 4'd5) & ~i_clear;

    // Pointers, counts and in-flight bits. Clearing the v bits is what
    // discards RAM data already in flight when the FIFO is flushed.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_count  <= '0;
            level      <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
            skid_head  <= '0;
            skid_tail  <= '0;
            skid_count <= '0;
        end else if (i_clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_count  <= '0;
            level      <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
            skid_head  <= '0;
            skid_tail  <= '0;
            skid_count <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            ram_count <= ram_count + {{AW{1'b0}}, wr_fire} - {{AW{1'b0}}, issue};
            level     <= level + {{AW{1'b0}}, wr_fire} - {{AW{1'b0}}, pop};
            v1 <= issue;
            v2 <= v1;
            v3 <= v2;
            if (push) begin
                skid_tail <= skid_inc(skid_tail);
            end
            if (pop) begin
                skid_head <= skid_inc(skid_head);
            end
            skid_count <= skid_count + {2'b00, push} - {2'b00, pop};
        end
    end

    // Skid storage holds data only; its occupancy lives in the pointers above.
    always_ff @(posedge i_clk) begin
        if (push && !i_clear) begin
            skid_mem[skid_tail] <= i_ram_rd_data;
        end
    end

endmodule

// File: doc/zap_ram_fifo_ctrl.md
Name: zap_ram_fifo_ctrl

Overview:
- Synchronous FIFO controller wrapped around one zap_ram_simple instance (3-cycle read latency, ports o_rd_data/i_wr_*/i_rd_addr).
- Drives the RAM's write and read ports and consumes its 3-cycle delayed read data.
- Presents a first-word-fall-through valid/ready read interface through a 5-entry register skid buffer.
- Intended for the fetch/store queues and other deep buffers in the core.

Parameters:
- WIDTH, 32, data width; must match the RAM instance.
- DEPTH, 32, RAM entries; power of 2, >= 8.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous flush.
- i_wr_valid  in  1  write request.
- o_wr_ready  out  1  space available; combinational, = (o_level < DEPTH).
- i_wr_data  in  WIDTH  write data.
- o_rd_valid  out  1  o_rd_data valid; = (skid count != 0).
- i_rd_ready  in  1  consumer accepts head.
- o_rd_data  out  WIDTH  skid head entry, registered.
- o_level  out  $clog2(DEPTH)+1  total occupancy.
- o_ram_wr_en  out  1  = i_wr_valid & o_wr_ready & ~i_clear.
- o_ram_wr_addr  out  $clog2(DEPTH)  write pointer.
- o_ram_wr_data  out  WIDTH  = i_wr_data.
- o_ram_rd_addr  out  $clog2(DEPTH)  read-issue pointer.
- i_ram_rd_data  in  WIDTH  RAM o_rd_data (3-cycle delayed).

Behaviour:
- Integration: the RAM's i_clken is tied to 1. The RAM pipeline always advances; the controller never stalls it.
- Reset (async, i_reset_n = 0):
  - wr_ptr, rd_ptr, ram_count, skid pointers/count, in-flight bits v1/v2/v3 all cleared to 0.
  - Outputs: o_rd_valid = 0, o_level = 0, o_wr_ready = 1, o_ram_wr_en = 0.
  - RAM contents are not reset.
- Write accept (wr_fire = i_wr_valid & o_wr_ready & ~i_clear): RAM is written at wr_ptr, then wr_ptr++ (wraps mod DEPTH) and ram_count++.
- Read issue:
  - Condition: issue = (ram_count != 0) & (skid_count + v1 + v2 + v3 < 5) & ~i_clear.
  - o_ram_rd_addr = rd_ptr every cycle. On issue: rd_ptr++ (wrap) and ram_count--.
  - The counts are registered values; the condition never depends on i_rd_ready.
- In-flight tracking:
  - Each edge: v1 <= issue, v2 <= v1, v3 <= v2.
  - An issue in cycle t has data on i_ram_rd_data in cycle t+3. When v3 = 1, that data is pushed into the skid tail at the edge ending that cycle.
- Skid buffer:
  - 5 entries, circular, registered. Pop when o_rd_valid & i_rd_ready.
  - Push and pop in the same cycle are legal; count is unchanged.
  - The issue condition guarantees no overflow with zero pops.
- Throughput and latency:
  - Steady state (skid 1 + in-flight 3 = 4 < 5) sustains 1 read per cycle with no bubbles.
  - Empty FIFO: write in cycle t gives issue in t+1 and o_rd_valid in t+5.
- Occupancy:
  - o_level = ram_count + v1 + v2 + v3 + skid_count. It increments on wr_fire and decrements on pop.
  - A RAM slot is freed only on pop. Therefore wr_ptr never equals an unread or in-flight address, so the RAM's internal write-forwarding paths never fire on live entries.
- Full: o_level = DEPTH gives o_wr_ready = 0; a write attempt is ignored and no state changes.
- Empty: a pop with o_rd_valid = 0 is ignored.
- Simultaneous write and pop at full: the write is refused. o_wr_ready is evaluated on the registered level, so a same-cycle pop does not allow the write.
- i_clear (priority over everything):
  - Next edge: pointers, counts, skid and v1..v3 return to reset values.
  - In-flight RAM data is discarded because its v bits are zeroed.
  - Same-cycle write and pop are dropped.
- Wrap-around: pointers are pure mod-DEPTH; data order is preserved across any number of wraps.
- Reset asserted mid-operation: immediate return to reset state; no output glitch to valid after deassertion.

Test Plan:
- Reset: assert i_reset_n = 0 mid-stream -> o_rd_valid = 0, o_level = 0, o_wr_ready = 1 immediately; first write after release behaves as from an empty FIFO.
- Single word: write 0xA5A50001 in cycle 0 with i_rd_ready = 1 -> o_rd_valid = 1 in cycle 5 with data 0xA5A50001; o_level is 1 in cycles 1-5 and 0 in cycle 6.
- Fill: 32 writes (0..31) with i_rd_ready = 0 -> o_wr_ready = 0 after the 32nd write, o_level = 32, a 33rd write is ignored, RAM reads stop with 5 entries in skid + flight; then drain -> exactly 0..31 in order.
- Streaming: writes 0..99 back-to-back with i_rd_ready = 1 -> outputs 0..99 on consecutive cycles starting cycle 5, no bubbles, no duplicates.
- Backpressure/wrap: 200 writes with random i_wr_valid and random 50% i_rd_ready, DEPTH = 8 -> scoreboard shows in-order, no loss, no duplication, o_level always matches the model and never exceeds 8.
- Clear: i_clear with 3 reads in flight and 2 entries in skid -> next cycle o_level = 0, o_rd_valid = 0, the flushed data never appears; a subsequent write of 0x1234 appears 5 cycles later.
